// File: rtl/zxuno_port_decoder_pkg.sv
// zxuno_port_decoder_pkg: shared ZX-Uno I/O port constants and decoder FSM state encoding
package zxuno_port_decoder_pkg;
  localparam logic [15:0] ZXUNO_IOADDR = 16'hFC3B;
  localparam logic [15:0] ZXUNO_IODATA = 16'hFD3B;
  typedef enum logic [2:0] {IDLE, ADDR_WR, DATA_WR, DATA_RD, WAIT_END} state_t;
endpackage

// File: rtl/zxuno_port_decoder.sv
// zxuno_port_decoder: decodes Z80 I/O cycles on IOADDR/IODATA into address latch, regrd level, regwr/regaddr_changed pulses; dout/oe_n give combinational IOADDR readback
module zxuno_port_decoder
  import zxuno_port_decoder_pkg::*;
#(
  parameter logic [15:0] IOADDR = ZXUNO_IOADDR,
  parameter logic [15:0] IODATA = ZXUNO_IODATA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        oe_n,
  output logic [7:0]  zxuno_addr,
  output logic        zxuno_regrd,
  output logic        zxuno_regwr,
  output logic        regaddr_changed
);
  state_t     r_state, w_next;
  logic [7:0] r_addr, w_addr;
  logic       r_regrd, r_regwr, r_changed, w_regrd, w_regwr, w_changed;
  logic       w_q;
  assign w_q = !iorq_n && m1_n;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= WAIT_END;
      r_addr    <= 8'h00;
      r_regrd   <= 1'b0;
      r_regwr   <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_addr    <= w_addr;
      r_regrd   <= w_regrd;
      r_regwr   <= w_regwr;
      r_changed <= w_changed;
    end
  end
  always_comb begin
    w_next    = r_state;
    w_addr    = r_addr;
    w_regrd   = 1'b0;
    w_regwr   = 1'b0;
    w_changed = 1'b0;
    case (r_state)
      IDLE:
        if (w_q && !wr_n && a == IOADDR) begin
          w_next    = ADDR_WR;
          w_addr    = din;
          w_changed = 1'b1;
        end else if (w_q && !wr_n && a == IODATA) begin
          w_next  = DATA_WR;
          w_regwr = 1'b1;
        end else if (w_q && !rd_n && a == IODATA) begin
          w_next  = DATA_RD;
          w_regrd = 1'b1;
        end
      DATA_RD: begin
        w_regrd = !iorq_n && !rd_n;
        w_next  = w_regrd ? DATA_RD : IDLE;
      end
      default: w_next = iorq_n ? IDLE : r_state;
    endcase
  end
  assign oe_n            = !(a == IOADDR && !iorq_n && !rd_n && m1_n);
  assign dout            = r_addr;
  assign zxuno_addr      = r_addr;
  assign zxuno_regrd     = r_regrd;
  assign zxuno_regwr     = r_regwr;
  assign regaddr_changed = r_changed;
endmodule

// File: tb/tb_zxuno_port_decoder.sv
// tb_zxuno_port_decoder: directed self-checking bench for zxuno_port_decoder
module tb_zxuno_port_decoder;
  logic        clk = 1'b0, rst_n = 1'b0, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1;
  logic [15:0] a = 16'h0000;
  logic [7:0]  din = 8'h00, dout, zxuno_addr;
  logic        oe_n, zxuno_regrd, zxuno_regwr, regaddr_changed;
  int          tests = 0, fails = 0, cnt = 0, rises = 0;
  logic        prev = 1'b0;
  zxuno_port_decoder dut (
    .clk(clk), .rst_n(rst_n), .a(a), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .din(din), .dout(dout), .oe_n(oe_n), .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
    .zxuno_regwr(zxuno_regwr), .regaddr_changed(regaddr_changed)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle_bus();
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
  endtask
  initial begin
    cyc(2);
    chk("rst_addr", zxuno_addr, 8'h00);
    chk("rst_regrd", zxuno_regrd, 0);
    chk("rst_regwr", zxuno_regwr, 0);
    chk("rst_chg", regaddr_changed, 0);
    rst_n = 1'b1;
    cyc(2);
    a = 16'hFC3B; din = 8'hFF; iorq_n = 1'b0; wr_n = 1'b0;
    cyc(1);
    chk("addr_ff_first_edge", zxuno_addr, 8'hFF);
    chk("chg_with_addr", regaddr_changed, 1);
    cnt = 1;
    for (int i = 0; i < 3; i++) begin cyc(1); cnt += regaddr_changed; end
    chk("chg_one_clk", cnt, 1);
    idle_bus(); cyc(1);
    iorq_n = 1'b0; rd_n = 1'b0; #1;
    chk("oe_n_rd_ioaddr", oe_n, 0);
    chk("dout_ff", dout, 8'hFF);
    cyc(1);
    chk("rd_ioaddr_no_regrd", zxuno_regrd, 0);
    chk("rd_ioaddr_no_chg", regaddr_changed, 0);
    idle_bus(); cyc(1);
    chk("oe_n_idle", oe_n, 1);
    a = 16'hFD3B; iorq_n = 1'b0; rd_n = 1'b0; cnt = 0;
    for (int i = 0; i < 6; i++) begin cyc(1); cnt += zxuno_regrd; end
    chk("regrd_6clk", cnt, 6);
    idle_bus(); #1;
    chk("regrd_fall_latency", zxuno_regrd, 1);
    cyc(1);
    chk("regrd_dropped", zxuno_regrd, 0);
    cnt = 0; rises = 0; prev = 1'b0;
    for (int r = 0; r < 3; r++) begin
      iorq_n = 1'b0; rd_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
        cyc(1);
        cnt += zxuno_regrd;
        rises += (zxuno_regrd && !prev) ? 1 : 0;
        prev = zxuno_regrd;
        if (i == 1) idle_bus();
      end
    end
    chk("three_reads_cycles", cnt, 6);
    chk("three_reads_windows", rises, 3);
    a = 16'hFD3B; din = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0; cnt = 0;
    for (int i = 0; i < 5; i++) begin cyc(1); cnt += zxuno_regwr; end
    chk("regwr_one_pulse", cnt, 1);
    idle_bus(); cyc(1);
    cnt = 0;
    iorq_n = 1'b0; wr_n = 1'b0;
    cyc(1); cnt += zxuno_regwr; cyc(1); cnt += zxuno_regwr;
    idle_bus(); cyc(1); cnt += zxuno_regwr;
    iorq_n = 1'b0; wr_n = 1'b0;
    cyc(1); cnt += zxuno_regwr; cyc(1); cnt += zxuno_regwr;
    chk("regwr_two_pulses", cnt, 2);
    idle_bus(); cyc(1);
    a = 16'hFC3B; iorq_n = 1'b0; m1_n = 1'b0; rd_n = 1'b0; #1;
    chk("inta_oe_n", oe_n, 1);
    a = 16'hFD3B; cnt = 0;
    for (int i = 0; i < 2; i++) begin cyc(1); cnt += zxuno_regrd + zxuno_regwr + regaddr_changed; end
    chk("inta_rd_no_strobe", cnt, 0);
    rd_n = 1'b1; wr_n = 1'b0; a = 16'hFC3B; din = 8'h11;
    cyc(2);
    chk("inta_wr_addr", zxuno_addr, 8'hFF);
    chk("inta_wr_no_chg", regaddr_changed, 0);
    idle_bus(); cyc(1);
    a = 16'hFC3A; din = 8'h33; iorq_n = 1'b0; wr_n = 1'b0;
    cyc(2);
    chk("fc3a_addr", zxuno_addr, 8'hFF);
    idle_bus(); cyc(1);
    a = 16'h003B; din = 8'h44; iorq_n = 1'b0; wr_n = 1'b0;
    cyc(2);
    chk("hibyte_mismatch_addr", zxuno_addr, 8'hFF);
    chk("hibyte_mismatch_chg", regaddr_changed, 0);
    idle_bus(); cyc(1);
    a = 16'hFC3B; din = 8'h07; cnt = 0;
    for (int w = 0; w < 2; w++) begin
      iorq_n = 1'b0; wr_n = 1'b0;
      cyc(1); cnt += regaddr_changed;
      chk("addr07_during_pulse", zxuno_addr, 8'h07);
      cyc(1); cnt += regaddr_changed;
      idle_bus(); cyc(1); cnt += regaddr_changed;
    end
    chk("same_addr_two_pulses", cnt, 2);
    a = 16'hFD3B; iorq_n = 1'b0; rd_n = 1'b0;
    cyc(2);
    chk("pre_reset_regrd", zxuno_regrd, 1);
    rst_n = 1'b0;
    cyc(1);
    chk("reset_regrd", zxuno_regrd, 0);
    chk("reset_addr", zxuno_addr, 8'h00);
    rst_n = 1'b1; cnt = 0;
    for (int i = 0; i < 3; i++) begin cyc(1); cnt += zxuno_regrd + zxuno_regwr + regaddr_changed; end
    chk("wait_end_no_strobe", cnt, 0);
    idle_bus(); cyc(1);
    iorq_n = 1'b0; rd_n = 1'b0;
    cyc(1);
    chk("post_reset_new_read", zxuno_regrd, 1);
    idle_bus(); cyc(1);
    a = 16'hFC3B; din = 8'h99; iorq_n = 1'b0; wr_n = 1'b0; rst_n = 1'b0;
    cyc(1);
    chk("reset_dominates_addr", zxuno_addr, 8'h00);
    chk("reset_dominates_chg", regaddr_changed, 0);
    rst_n = 1'b1; idle_bus(); cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/zxuno_port_decoder.md
ZXUNO_PORT_DECODER -- requirements
Module: zxuno_port_decoder

Interface
REQ-001 Parameter IOADDR, default 16'hFC3B, meaning the CPU I/O port that holds the register-address latch.
REQ-002 Parameter IODATA, default 16'hFD3B, meaning the CPU I/O port for register data read/write.
REQ-003 clk  in  1  system clock; single clock domain, all outputs change only on rising edge except oe_n and dout.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 a  in  16  CPU address bus.
REQ-006 iorq_n  in  1  CPU I/O request, active-low.
REQ-007 rd_n  in  1  CPU read strobe, active-low.
REQ-008 wr_n  in  1  CPU write strobe, active-low.
REQ-009 m1_n  in  1  CPU M1, active-low; iorq_n low with m1_n low is interrupt acknowledge.
REQ-010 din  in  8  CPU data bus (write data).
REQ-011 dout  out  8  readback of current register address; valid whenever oe_n is low.
REQ-012 oe_n  out  1  low combinationally while a==IOADDR, iorq_n, rd_n low, m1_n high.
REQ-013 zxuno_addr  out  8  latched register address.
REQ-014 zxuno_regrd  out  1  registered level, high for the duration of a qualified IODATA read cycle.
REQ-015 zxuno_regwr  out  1  registered one-cycle pulse per qualified IODATA write cycle.
REQ-016 regaddr_changed  out  1  registered one-cycle pulse per IOADDR write cycle.

Function
REQ-017 Qualified I/O cycle: iorq_n==0 && m1_n==1, sampled at rising clk; interrupt acknowledge SHALL never produce any strobe.
REQ-018 FSM states: IDLE, ADDR_WR, DATA_WR, DATA_RD, WAIT_END.
REQ-019 IDLE -> ADDR_WR when qualified, wr_n==0, a==IOADDR; same edge: zxuno_addr<=din, regaddr_changed<=1.
REQ-020 IDLE -> DATA_WR when qualified, wr_n==0, a==IODATA; same edge: zxuno_regwr<=1.
REQ-021 IDLE -> DATA_RD when qualified, rd_n==0, a==IODATA; same edge: zxuno_regrd<=1.
REQ-022 Any other sample in IDLE: stay IDLE, all strobes 0.
REQ-023 ADDR_WR/DATA_WR: regaddr_changed/zxuno_regwr SHALL drop after exactly one cycle regardless of cycle length; hold state until iorq_n==1, then IDLE.
REQ-024 DATA_RD: zxuno_regrd stays 1 while iorq_n==0 and rd_n==0; on first sample with either high, regrd<=0, go IDLE (one-cycle registered fall latency).
REQ-025 A new strobe SHALL require return to IDLE; back-to-back cycles separated by at least one sample with iorq_n==1 SHALL each produce their own strobe.
REQ-026 zxuno_addr and regaddr_changed update on the same edge, so consumers see the new address while the pulse is high.
REQ-027 Writing the same address value again SHALL still pulse regaddr_changed.
REQ-028 Reading IOADDR SHALL not change FSM state or any registered output; dout==zxuno_addr.
REQ-029 Address compare is full 16-bit; mismatched high byte SHALL be ignored.

Reset
REQ-030 On rst_n==0 at a rising edge: zxuno_addr=8'h00, zxuno_regrd=0, zxuno_regwr=0, regaddr_changed=0, FSM=WAIT_END.
REQ-031 WAIT_END -> IDLE only after a sample with iorq_n==1; a CPU cycle in progress across reset release SHALL produce no strobe.
REQ-032 Reset dominates any simultaneous CPU cycle start.

Structure
REQ-033 Shared package holds IOADDR/IODATA default constants and the FSM state encoding; consumer register blocks import the same port constants.
REQ-034 No sub-module; single FSM plus address latch.

Verification
REQ-035 OUT (FC3B),8'hFF for 4 clks -> zxuno_addr=FF next edge, regaddr_changed high exactly 1 clk, dout=FF on IN FC3B.
REQ-036 OUT FC3B=FF then IN FD3B rd_n low 6 clks -> regrd high 6 clks, drops 1 clk after rd_n rises; repeat 3 reads -> 3 separate regrd windows.
REQ-037 OUT (FD3B),8'h5A held 5 clks -> zxuno_regwr high exactly 1 clk; two writes separated by 1 clk iorq_n high -> 2 pulses.
REQ-038 iorq_n=0, m1_n=0, a=FD3B, rd_n=0 -> no strobes, oe_n=1; a=FC3A write -> zxuno_addr unchanged.
REQ-039 Assert rst_n low mid-DATA_RD, release with cycle still active -> regrd=0, zxuno_addr=00, no strobe until iorq_n high then new cycle.
REQ-040 Write FC3B=8'h07 twice -> two regaddr_changed pulses, zxuno_addr=07.
